// File: rtl/reg16_pkg.sv
// Shared constants and helpers for the sequential 8x8 multiplier datapath.
package reg16_pkg;

    // Width of the product/accumulator word carried through the datapath.
    localparam int PROD_W = 16;

    // What the holding register does on a rising clock edge.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_CLEAR = 2'd2
    } reg_action_e;

    // Clear dominates load; with neither requested the register holds.
    function automatic reg_action_e edge_action(input logic sclr_n, input logic clk_ena);
        if (!sclr_n) begin
            return ACT_CLEAR;
        end else if (clk_ena) begin
            return ACT_LOAD;
        end
        return ACT_HOLD;
    endfunction

endpackage

// File: rtl/reg16.sv
// Clock-enabled holding register for the multiplier product/accumulator.
// Asynchronous active-high reset, synchronous active-low clear that wins over
// load, and a plain bit-for-bit load when enabled. reg_out comes straight
// from the flops.
module reg16
    import reg16_pkg::*;
#(
    parameter int WIDTH = PROD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclr_n,
    input  logic             clk_ena,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] reg_out
);

    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;
    reg_action_e      action;

    // Decide the edge action and the value the register takes on the next edge.
    always_comb begin
        reg_d  = reg_q;
        action = edge_action(sclr_n, clk_ena);
        case (action)
            ACT_CLEAR: reg_d = '0;
            ACT_LOAD:  reg_d = datain;
            default:   reg_d = reg_q;
        endcase
    end

    // State register: reset clears immediately, otherwise take the next value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign reg_out = reg_q;

    // Control inputs must be known whenever an edge can act on them.
    a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({sclr_n, clk_ena}))
        else $error("reg16: X/Z on sclr_n or clk_ena");

    c_reset: cover property (@(posedge clk) rst);
    c_clear: cover property (@(posedge clk) disable iff (rst) !sclr_n);
    c_clear_over_load: cover property (@(posedge clk) disable iff (rst) !sclr_n && clk_ena);
    c_load:  cover property (@(posedge clk) disable iff (rst) sclr_n && clk_ena);
    c_hold:  cover property (@(posedge clk) disable iff (rst) sclr_n && !clk_ena);

endmodule

// File: tb/tb_reg16.sv
// Self-checking bench for reg16: directed scenarios plus randomized traffic
// against a behavioural model of the holding register.
module tb_reg16;

    localparam int W = reg16_pkg::PROD_W;

    logic         clk;
    logic         rst;
    logic         sclr_n;
    logic         clk_ena;
    logic [W-1:0] datain;
    logic [W-1:0] reg_out;

    int checks = 0;
    int errors = 0;

    // Behavioural model: the value reg_out must show.
    logic [W-1:0] exp_val;

    reg16 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .sclr_n  (sclr_n),
        .clk_ena (clk_ena),
        .datain  (datain),
        .reg_out (reg_out)
    );

    // Clock: starts high so the first rising edge is at 10 ns, period 10 ns.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // One rising edge: update the model from the inputs present at the edge,
    // then land 1 ns after the edge so outputs are sampled away from it.
    task automatic tick();
        if (!rst) begin
            if (!sclr_n)      exp_val = '0;
            else if (clk_ena) exp_val = datain;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        sclr_n  = 1'b1;
        clk_ena = 1'b1;
        datain  = W'(600);
        exp_val = '0;
        #2;
        checks++;
        if (reg_out !== '0) begin
            errors++;
            $display("FAIL reset_no_edge: reg_out=%h expected=%h", reg_out, W'(0));
        end
        #10; // t=12, past the 10 ns edge with rst still high
        checks++;
        if (reg_out !== '0) begin
            errors++;
            $display("FAIL reset_held: reg_out=%h expected=%h", reg_out, W'(0));
        end
        #3;  // t=15, release mid-cycle
        rst     = 1'b0;
        clk_ena = 1'b0;
        tick();
        checks++;
        if (reg_out !== '0) begin
            errors++;
            $display("FAIL reset_release_hold: reg_out=%h expected=%h", reg_out, W'(0));
        end
    endtask

    task automatic test_sync_clear();
        clk_ena = 1'b1;
        datain  = W'(16'h1234);
        tick();
        checks++;
        if (reg_out !== W'(16'h1234)) begin
            errors++;
            $display("FAIL clear_setup_load: reg_out=%h expected=%h", reg_out, W'(16'h1234));
        end
        sclr_n = 1'b0;
        tick();
        checks++;
        if (reg_out !== '0) begin
            errors++;
            $display("FAIL sync_clear: reg_out=%h expected=%h", reg_out, W'(0));
        end
        sclr_n = 1'b1;
    endtask

    task automatic test_hold();
        clk_ena = 1'b0;
        datain  = W'(600);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (reg_out !== '0) begin
                errors++;
                $display("FAIL hold_%0d: reg_out=%h expected=%h", i, reg_out, W'(0));
            end
        end
    endtask

    task automatic test_load();
        clk_ena = 1'b1;
        datain  = W'(600);
        tick();
        checks++;
        if (reg_out !== W'(16'h0258)) begin
            errors++;
            $display("FAIL load_600: reg_out=%h expected=%h", reg_out, W'(16'h0258));
        end
        datain = W'(16'hFFFF);
        tick();
        checks++;
        if (reg_out !== W'(16'hFFFF)) begin
            errors++;
            $display("FAIL load_ffff: reg_out=%h expected=%h", reg_out, W'(16'hFFFF));
        end
    endtask

    task automatic test_async_reset();
        clk_ena = 1'b0;
        #2;
        rst = 1'b1;
        exp_val = '0;
        #1;
        checks++;
        if (reg_out !== '0) begin
            errors++;
            $display("FAIL async_reset_immediate: reg_out=%h expected=%h", reg_out, W'(0));
        end
        #1;
        rst     = 1'b0;
        clk_ena = 1'b1;
        datain  = W'(16'h00AA);
        tick();
        checks++;
        if (reg_out !== W'(16'h00AA)) begin
            errors++;
            $display("FAIL async_reset_first_load: reg_out=%h expected=%h", reg_out, W'(16'h00AA));
        end
    endtask

    task automatic test_clear_vs_load();
        sclr_n  = 1'b0;
        clk_ena = 1'b1;
        datain  = W'(16'hBEEF);
        tick();
        checks++;
        if (reg_out !== '0) begin
            errors++;
            $display("FAIL clear_beats_load: reg_out=%h expected=%h", reg_out, W'(0));
        end
        sclr_n = 1'b1;
        tick();
        checks++;
        if (reg_out !== W'(16'hBEEF)) begin
            errors++;
            $display("FAIL load_after_clear: reg_out=%h expected=%h", reg_out, W'(16'hBEEF));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            sclr_n  = ($urandom_range(0, 7) != 0);
            clk_ena = 1'($urandom_range(0, 1));
            datain  = W'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                // Short asynchronous reset pulse between edges.
                rst = 1'b1;
                exp_val = '0;
                #1;
                checks++;
                if (reg_out !== '0) begin
                    errors++;
                    $display("FAIL random_async_%0d: reg_out=%h expected=%h", i, reg_out, W'(0));
                end
                rst = 1'b0;
            end
            tick();
            checks++;
            if (reg_out !== exp_val) begin
                errors++;
                $display("FAIL random_%0d: reg_out=%h expected=%h", i, reg_out, exp_val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sync_clear();
        test_hold();
        test_load();
        test_async_reset();
        test_clear_vs_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
